// File: rtl/binary_search_pkg.sv
// Shared types and helpers for the sorted insert buffer and the search engine
// it feeds: FSM state encoding, pad-value constant and count-width helper.
package binary_search_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } sib_state_t;

  // All-ones pad of width w (w <= 64); callers slice the low w bits.
  function automatic logic [63:0] sib_pad(input int unsigned w);
    return ~64'd0 >> (64 - w);
  endfunction

  // Width needed to hold a count of 0..n inclusive.
  function automatic int unsigned sib_cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sorted_insert_cell.sv
// One slot of the insertion-sorted array. On a load it either keeps its value,
// takes the incoming value, or takes its left neighbour's value (shift right).
// Pad slots hold the all-ones maximum, so the same rule also places the value
// in the first pad slot when it is the new maximum.
module sorted_insert_cell #(
  parameter int                    DATA_WIDTH = 8,
  parameter bit                    FIRST      = 1'b0,
  parameter logic [DATA_WIDTH-1:0] PAD        = '1
) (
  input  logic [DATA_WIDTH-1:0] cur_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] val_i,
  input  logic                  slot_valid_i,
  input  logic                  load_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] nxt_o
);

  // Next slot value: clear to pad, shift/insert on load, otherwise hold.
  always_comb begin
    nxt_o = cur_i;
    if (clear_i) begin
      nxt_o = PAD;
    end else if (load_i && slot_valid_i && (cur_i > val_i)) begin
      nxt_o = (FIRST || (left_i <= val_i)) ? val_i : left_i;
    end
  end

endmodule

// File: rtl/sorted_insert_buffer.sv
// Insertion-sorting front end for the binary search engine. Accepts one value
// per cycle, keeps an ascending array padded with all-ones, then presents it
// with a one-cycle start pulse and holds it until clear.
// Optional build macro SORTED_INSERT_DEDUP_EN: values already present in the
// array are consumed without insertion (in_last on them still completes).
module sorted_insert_buffer
  import binary_search_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 10,
  parameter int CNT_W      = sib_cnt_w(ARRAY_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic                                   in_last,
  input  logic                                   clear,
  output logic [0:ARRAY_SIZE-1][DATA_WIDTH-1:0]  out_data,
  output logic [CNT_W-1:0]                       count,
  output logic                                   sorted_valid,
  output logic                                   start
);

  localparam logic [63:0]           PAD64 = sib_pad(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] PAD   = PAD64[DATA_WIDTH-1:0];
  localparam logic [CNT_W-1:0]      FULL  = CNT_W'(ARRAY_SIZE);

  sib_state_t                             state_q;
  logic [0:ARRAY_SIZE-1][DATA_WIDTH-1:0]  arr_q, arr_d;
  logic [CNT_W-1:0]                       count_q, cnt_nxt;
  logic                                   in_ready_q, sorted_valid_q, start_q;
  logic                                   accept, dup, insert, done_now;
  logic [ARRAY_SIZE-1:0]                  hit;

  assign accept   = in_valid & in_ready_q;
  assign insert   = accept & ~dup;
  assign cnt_nxt  = insert ? count_q + 1'b1 : count_q;
  assign done_now = accept & (in_last | (cnt_nxt == FULL));

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_slot
    logic [DATA_WIDTH-1:0] left;
    if (i == 0) begin : g_l0
      assign left = PAD;
    end else begin : g_ln
      assign left = arr_q[i-1];
    end

`ifdef SORTED_INSERT_DEDUP_EN
    assign hit[i] = (CNT_W'(i) < count_q) && (arr_q[i] == in_data);
`else
    assign hit[i] = 1'b0;
`endif

    sorted_insert_cell #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIRST      (i == 0),
      .PAD        (PAD)
    ) u_cell (
      .cur_i        (arr_q[i]),
      .left_i       (left),
      .val_i        (in_data),
      .slot_valid_i (CNT_W'(i) <= count_q),
      .load_i       (insert),
      .clear_i      (clear),
      .nxt_o        (arr_d[i])
    );
  end

  assign dup = |hit;

  // Slot registers; the cells already fold in clear priority over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARRAY_SIZE; i++) arr_q[i] <= PAD;
    end else begin
      arr_q <= arr_d;
    end
  end

  // Control FSM with registered handshake/status outputs and slot counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      in_ready_q     <= 1'b1;
      sorted_valid_q <= 1'b0;
      start_q        <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (clear) begin
        state_q        <= IDLE;
        count_q        <= '0;
        in_ready_q     <= 1'b1;
        sorted_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, FILL: begin
            if (accept) begin
              count_q <= cnt_nxt;
              if (done_now) begin
                state_q        <= DONE;
                in_ready_q     <= 1'b0;
                sorted_valid_q <= 1'b1;
                start_q        <= 1'b1;
              end else begin
                state_q <= FILL;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_data     = arr_q;
  assign count        = count_q;
  assign in_ready     = in_ready_q;
  assign sorted_valid = sorted_valid_q;
  assign start        = start_q;

endmodule

// File: tb/tb_sorted_insert_buffer.sv
// Bench for sorted_insert_buffer: directed scenarios plus randomized loads,
// checked against a queue-based sorted-list model.
`timescale 1ns/1ps
module tb_sorted_insert_buffer;
  localparam int DW = 8;
  localparam int AS = 10;
  localparam int CW = $clog2(AS + 1);
  typedef logic [0:AS-1][DW-1:0] arr_t;

  logic          clk, rst_n, in_valid, in_ready, in_last, clear, sorted_valid, start;
  logic [DW-1:0] in_data;
  arr_t          out_data;
  logic [CW-1:0] count;

  int            n_chk, n_pass;
  logic [DW-1:0] mq[$];
  bit            m_done;

  sorted_insert_buffer #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .clear(clear), .out_data(out_data),
    .count(count), .sorted_valid(sorted_valid), .start(start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected array: model contents ascending, then pad.
  function automatic arr_t exp_arr();
    arr_t e;
    for (int i = 0; i < AS; i++) e[i] = (i < mq.size()) ? mq[i] : 8'hFF;
    return e;
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_done = 1'b0;
  endfunction

  // Sorted-list insert after equal entries; returns 1 when the load completes.
  function automatic bit model_accept(input logic [DW-1:0] v, input bit last);
    int pos;
    bit found;
    if (m_done) return 1'b0;
    found = 1'b0;
`ifdef SORTED_INSERT_DEDUP_EN
    foreach (mq[k]) if (mq[k] == v) found = 1'b1;
`endif
    if (!found) begin
      pos = mq.size();
      for (int k = 0; k < mq.size(); k++) begin
        if (mq[k] > v) begin
          pos = k;
          break;
        end
      end
      mq.insert(pos, v);
    end
    if (last || mq.size() == AS) begin
      m_done = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] v, input bit last, output bit done);
    in_valid = 1'b1; in_data = v; in_last = last;
    cyc();
    done = model_accept(v, last);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; clear = 1'b0;
    model_clear();
    #12;
    @(negedge clk) rst_n = 1'b1;
    cyc();
    n_chk++; if (out_data !== exp_arr()) $display("FAIL reset_out_data: got %h expected %h", out_data, exp_arr()); else n_pass++;
    n_chk++; if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_chk++; if (sorted_valid !== 1'b0) $display("FAIL reset_sorted_valid: got %b expected 0", sorted_valid); else n_pass++;
    n_chk++; if (start !== 1'b0) $display("FAIL reset_start: got %b expected 0", start); else n_pass++;
  endtask

  task automatic test_basic_sort();
    logic [DW-1:0] vals[5];
    bit done;
    vals = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd5};
    for (int k = 0; k < 5; k++) begin
      drive(vals[k], k == 4, done);
      n_chk++; if (count !== CW'(mq.size())) $display("FAIL basic_count: got %0d expected %0d", count, mq.size()); else n_pass++;
      n_chk++; if (start !== done) $display("FAIL basic_start: got %b expected %b", start, done); else n_pass++;
    end
    n_chk++; if (out_data !== exp_arr()) $display("FAIL basic_out_data: got %h expected %h", out_data, exp_arr()); else n_pass++;
    n_chk++; if (in_ready !== 1'b0 || sorted_valid !== 1'b1) $display("FAIL basic_done_flags: got ready=%b sv=%b expected ready=0 sv=1", in_ready, sorted_valid); else n_pass++;
    cyc();
    n_chk++; if (start !== 1'b0) $display("FAIL basic_start_width: got %b expected 0", start); else n_pass++;
    n_chk++; if (out_data !== exp_arr() || sorted_valid !== 1'b1) $display("FAIL basic_hold: got %h sv=%b expected %h sv=1", out_data, sorted_valid, exp_arr()); else n_pass++;
    do_clear();
    n_chk++; if (sorted_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0) $display("FAIL basic_clear: got sv=%b ready=%b count=%0d expected 0 1 0", sorted_valid, in_ready, count); else n_pass++;
  endtask

  task automatic test_autofill();
    bit done;
    for (int k = 0; k < AS; k++) begin
      drive(DW'(90 - k), 1'b0, done);
      n_chk++; if (start !== done) $display("FAIL fill_start: got %b expected %b at k=%0d", start, done, k); else n_pass++;
    end
    n_chk++; if (count !== CW'(AS) || out_data !== exp_arr()) $display("FAIL fill_result: got count=%0d %h expected %0d %h", count, out_data, AS, exp_arr()); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL fill_ready: got %b expected 0", in_ready); else n_pass++;
    in_valid = 1'b1; in_data = 8'd80;
    for (int k = 0; k < 3; k++) begin
      cyc();
      n_chk++; if (count !== CW'(AS) || out_data !== exp_arr() || start !== 1'b0) $display("FAIL fill_extra_ignored: got count=%0d start=%b %h expected %0d 0 %h", count, start, out_data, AS, exp_arr()); else n_pass++;
    end
    in_valid = 1'b0;
    do_clear();
  endtask

  task automatic test_dup();
    bit done;
    drive(8'd4, 1'b0, done);
    drive(8'd4, 1'b0, done);
    drive(8'd2, 1'b1, done);
    n_chk++; if (count !== CW'(mq.size())) $display("FAIL dup_count: got %0d expected %0d", count, mq.size()); else n_pass++;
    n_chk++; if (out_data !== exp_arr()) $display("FAIL dup_out_data: got %h expected %h", out_data, exp_arr()); else n_pass++;
    n_chk++; if (start !== 1'b1) $display("FAIL dup_start: got %b expected 1", start); else n_pass++;
    do_clear();
  endtask

  task automatic test_clear_mid();
    bit done;
    drive(8'd12, 1'b0, done);
    drive(8'd8, 1'b0, done);
    drive(8'd30, 1'b0, done);
    in_valid = 1'b1; in_data = 8'd50; clear = 1'b1;
    cyc();
    in_valid = 1'b0; clear = 1'b0;
    model_clear();
    n_chk++; if (count !== '0 || out_data !== exp_arr()) $display("FAIL clear_mid_data: got count=%0d %h expected 0 %h", count, out_data, exp_arr()); else n_pass++;
    n_chk++; if (in_ready !== 1'b1 || sorted_valid !== 1'b0 || start !== 1'b0) $display("FAIL clear_mid_flags: got ready=%b sv=%b start=%b expected 1 0 0", in_ready, sorted_valid, start); else n_pass++;
    drive(8'd20, 1'b1, done);
    n_chk++; if (count !== 1 || start !== 1'b1 || out_data !== exp_arr()) $display("FAIL clear_mid_reload: got count=%0d start=%b %h expected 1 1 %h", count, start, out_data, exp_arr()); else n_pass++;
    do_clear();
  endtask

  task automatic test_async_reset();
    bit done, seen;
    drive(8'd40, 1'b0, done);
    drive(8'd10, 1'b0, done);
    drive(8'd25, 1'b0, done);
    #3 rst_n = 1'b0;
    #1;
    model_clear();
    n_chk++; if (count !== '0 || out_data !== exp_arr()) $display("FAIL arst_data: got count=%0d %h expected 0 %h", count, out_data, exp_arr()); else n_pass++;
    n_chk++; if (in_ready !== 1'b1 || sorted_valid !== 1'b0 || start !== 1'b0) $display("FAIL arst_flags: got ready=%b sv=%b start=%b expected 1 0 0", in_ready, sorted_valid, start); else n_pass++;
    cyc();
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (start !== 1'b0) seen = 1'b1;
    end
    n_chk++; if (seen) $display("FAIL arst_no_start: got start pulse expected none"); else n_pass++;
  endtask

  task automatic test_random();
    int len, sent, cycles;
    bit valid, last, done;
    logic [DW-1:0] v;
    for (int ld = 0; ld < 20; ld++) begin
      len = $urandom_range(1, 12);
      sent = 0; cycles = 0;
      while (!m_done && cycles < 60) begin
        valid = ($urandom_range(0, 3) != 0) || (cycles > 30);
        v = (ld % 2) ? DW'($urandom_range(0, 7)) : DW'($urandom_range(0, 255));
        last = (sent == len - 1);
        in_valid = valid; in_data = v; in_last = last;
        cyc();
        cycles++;
        done = 1'b0;
        if (valid) begin
          done = model_accept(v, last);
          sent++;
        end
        in_valid = 1'b0; in_last = 1'b0;
        n_chk++; if (count !== CW'(mq.size()) || out_data !== exp_arr()) $display("FAIL rand_state: load %0d got count=%0d %h expected %0d %h", ld, count, out_data, mq.size(), exp_arr()); else n_pass++;
        n_chk++; if (start !== done) $display("FAIL rand_start: load %0d got %b expected %b", ld, start, done); else n_pass++;
      end
      n_chk++; if (!m_done || sorted_valid !== 1'b1) $display("FAIL rand_complete: load %0d got sv=%b expected 1 within budget", ld, sorted_valid); else n_pass++;
      cyc();
      n_chk++; if (start !== 1'b0 || in_ready !== 1'b0) $display("FAIL rand_post: load %0d got start=%b ready=%b expected 0 0", ld, start, in_ready); else n_pass++;
      do_clear();
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_basic_sort();
    test_autofill();
    test_dup();
    test_clear_mid();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
